time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/microondas_pkg.sv | 25 ++
 rtl/btn_repeat.sv | 60 ++++++
 rtl/edge_detector.sv | 21 ++
 rtl/time_entry.sv | 147 ++++++++++++++
 tb/tb_time_entry.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/microondas_pkg.sv
// Shared definitions for the microwave front panel: controller states, digit limits, cursor slots.
// Latency: none (types, constants and one pure function).
// Backpressure: not applicable.
package microondas_pkg;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  localparam logic [3:0] UNIT_MAX     = 4'd9;
  localparam logic [3:0] TENS_SEC_MAX = 4'd5;

  localparam logic [1:0] CUR_SU = 2'd0;
  localparam logic [1:0] CUR_SD = 2'd1;
  localparam logic [1:0] CUR_MU = 2'd2;
  localparam logic [1:0] CUR_MD = 2'd3;

  // Only the seconds-tens digit stops at 5; every other digit runs 0..9.
  function automatic logic [3:0] digit_max(input logic [1:0] cur);
    return (cur == CUR_SD) ? TENS_SEC_MAX : UNIT_MAX;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus auto-repeat: step on press, again after REPEAT_DELAY, then every REPEAT_RATE.
// Latency: steps are combinational in the cycle they fall due.
// Backpressure: none; releasing the button stops stepping in the same cycle.
module btn_repeat #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise,
  output logic step
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);

  logic          armed;
  logic          repeating;
  logic [CW-1:0] cnt;
  logic          delay_hit;
  logic          rate_hit;

  edge_detector u_edge (
    .clock (clock),
    .reset (reset),
    .sig   (btn),
    .rise  (rise)
  );

  // cnt holds the cycles elapsed since the press, or since the last repeat once repeating.
  assign delay_hit = armed & ~repeating & (cnt == CW'(REPEAT_DELAY));
  assign rate_hit  = armed &  repeating & (cnt == CW'(REPEAT_RATE));
  assign step      = rise | (btn & (delay_hit | rate_hit));

  // Arm on a fresh press, restart the interval after each repeat step, disarm on release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else if (!btn) begin
      armed     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else if (rise) begin
      armed     <= 1'b1;
      repeating <= 1'b0;
      cnt       <= CW'(1);
    end else if (armed) begin
      if (delay_hit || rate_hit) begin
        repeating <= 1'b1;
        cnt       <= CW'(1);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_detector.sv
// Rising-edge detector for an already synchronised level input.
// Latency: rise is combinational in the cycle the level first reads high.
// Backpressure: none; a level held through reset needs a release and a fresh press.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  // Previous level; reset treats the input as already held so no edge is seen on release of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/time_entry.sv
// Microwave time entry: four BCD digits edited by buttons, start handshake to the timer, alarm beeper.
// Latency: digits/cursor update on the edge after a step; start pulses one cycle after the start_req edge.
// Backpressure: none; buttons are ignored while the timer runs, done outside RUN is dropped.
module time_entry #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_RATE   = 10_000_000,
  parameter int ALARM_HALF    = 25_000_000,
  parameter int ALARM_TOGGLES = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_clear,
  input  logic       start_req,
  input  logic       done,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       start,
  output logic [1:0] cursor,
  output logic       busy,
  output logic       alarm
);

  import microondas_pkg::*;

  localparam int AW = $clog2(ALARM_HALF + 1);
  localparam int HW = $clog2(ALARM_TOGGLES + 1);

  state_t          state, state_n;
  logic            start_n;
  logic [3:0][3:0] dig, dig_n;
  logic [1:0]      cur_n;
  logic [AW-1:0]   acnt;
  logic [HW-1:0]   hcnt;

  logic up_rise, up_step, dn_rise, dn_step;
  logic nxt_rise, clr_rise, go_rise;
  logic any_rise, nonzero, alarm_last;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clock (clock), .reset (reset), .btn (btn_up), .rise (up_rise), .step (up_step)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clock (clock), .reset (reset), .btn (btn_down), .rise (dn_rise), .step (dn_step)
  );

  edge_detector u_next  (.clock (clock), .reset (reset), .sig (btn_next),  .rise (nxt_rise));
  edge_detector u_clear (.clock (clock), .reset (reset), .sig (btn_clear), .rise (clr_rise));
  edge_detector u_go    (.clock (clock), .reset (reset), .sig (start_req), .rise (go_rise));

  assign any_rise   = up_rise | dn_rise | nxt_rise | clr_rise;
  assign nonzero    = |dig;
  assign alarm_last = (acnt == AW'(ALARM_HALF - 1)) && (hcnt == HW'(ALARM_TOGGLES - 1));

  assign min  = 7'(dig[CUR_MD]) * 7'd10 + 7'(dig[CUR_MU]);
  assign sec  = 7'(dig[CUR_SD]) * 7'd10 + 7'(dig[CUR_SU]);
  assign busy = (state == ST_RUN);

  // Next state and start request: only a nonzero value may be handed to the timer.
  always_comb begin
    state_n = state;
    start_n = 1'b0;
    case (state)
      ST_EDIT:  if (go_rise && nonzero) begin
                  state_n = ST_RUN;
                  start_n = 1'b1;
                end
      ST_RUN:   if (done) state_n = ST_ALARM;
      ST_ALARM: if (any_rise || alarm_last) state_n = ST_EDIT;
      default:  state_n = ST_EDIT;
    endcase
  end

  // State register; start is registered so it lands one cycle after the request edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_EDIT;
      start <= 1'b0;
    end else begin
      state <= state_n;
      start <= start_n;
    end
  end

  // Digit editing: clear wins, opposing steps cancel, no carry, cursor moves after the step lands.
  always_comb begin
    dig_n = dig;
    cur_n = cursor;
    if (state == ST_EDIT) begin
      if (clr_rise) begin
        dig_n = '0;
        cur_n = CUR_SU;
      end else begin
        if (up_step && !dn_step)
          dig_n[cursor] = (dig[cursor] == digit_max(cursor)) ? 4'd0 : dig[cursor] + 4'd1;
        else if (dn_step && !up_step)
          dig_n[cursor] = (dig[cursor] == 4'd0) ? digit_max(cursor) : dig[cursor] - 4'd1;
        if (nxt_rise) cur_n = cursor + 2'd1;
      end
    end
  end

  // Digit and cursor registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dig    <= '0;
      cursor <= CUR_SU;
    end else begin
      dig    <= dig_n;
      cursor <= cur_n;
    end
  end

  // Alarm pattern: starts high on done, flips every ALARM_HALF cycles, any button edge silences it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm <= 1'b0;
      acnt  <= '0;
      hcnt  <= '0;
    end else if (state == ST_RUN && done) begin
      alarm <= 1'b1;
      acnt  <= '0;
      hcnt  <= '0;
    end else if (state == ST_ALARM) begin
      if (any_rise) begin
        alarm <= 1'b0;
        acnt  <= '0;
        hcnt  <= '0;
      end else if (acnt == AW'(ALARM_HALF - 1)) begin
        acnt <= '0;
        if (hcnt == HW'(ALARM_TOGGLES - 1)) begin
          alarm <= 1'b0;
          hcnt  <= '0;
        end else begin
          alarm <= ~alarm;
          hcnt  <= hcnt + 1'b1;
        end
      end else begin
        acnt <= acnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_entry.sv
// Randomised and directed bench for time_entry against a cycle-count reference model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: not applicable.
module tb_time_entry;

  localparam int D = 20;
  localparam int R = 5;
  localparam int H = 4;
  localparam int T = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btns;   // 0 up, 1 down, 2 next, 3 clear, 4 start_req
  logic       done;
  logic [6:0] min, sec;
  logic       start, busy, alarm;
  logic [1:0] cursor;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;

  // reference model state
  int m_dig[4];
  int m_cur, m_mode, m_t, m_hold[2];
  bit m_start, m_alarm;
  bit m_prev[5];

  time_entry #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .ALARM_HALF(H), .ALARM_TOGGLES(T)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_up    (btns[0]),
    .btn_down  (btns[1]),
    .btn_next  (btns[2]),
    .btn_clear (btns[3]),
    .start_req (btns[4]),
    .done      (done),
    .min       (min),
    .sec       (sec),
    .start     (start),
    .cursor    (cursor),
    .busy      (busy),
    .alarm     (alarm)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lim(input int i);
    return (i == 1) ? 5 : 9;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    for (int i = 0; i < 5; i++) m_prev[i] = 1'b1;
    m_hold[0] = -1;
    m_hold[1] = -1;
    m_cur = 0; m_mode = 0; m_t = 0;
    m_start = 1'b0; m_alarm = 1'b0;
  endtask

  // Modes: 0 edit, 1 run, 2 alarm. Steps from press age: 0, D, D+R, D+2R, ...
  task automatic model_step();
    bit rs[5];
    bit st[2];
    bit any;
    int sum;
    for (int i = 0; i < 5; i++) rs[i] = btns[i] && !m_prev[i];
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0;
      if (rs[k]) begin
        m_hold[k] = 0;
        st[k] = 1'b1;
      end else if (btns[k] && m_hold[k] >= 0) begin
        m_hold[k]++;
        st[k] = (m_hold[k] == D) || (m_hold[k] > D && (m_hold[k] - D) % R == 0);
      end else begin
        m_hold[k] = -1;
      end
    end
    any = rs[0] | rs[1] | rs[2] | rs[3];
    sum = m_dig[0] + m_dig[1] + m_dig[2] + m_dig[3];
    m_start = 1'b0;
    case (m_mode)
      0: begin
        if (rs[4] && sum != 0) begin
          m_start = 1'b1;
          m_mode = 1;
        end
        if (rs[3]) begin
          for (int i = 0; i < 4; i++) m_dig[i] = 0;
          m_cur = 0;
        end else begin
          if (st[0] && !st[1]) m_dig[m_cur] = (m_dig[m_cur] + 1) % (lim(m_cur) + 1);
          else if (st[1] && !st[0]) m_dig[m_cur] = (m_dig[m_cur] + lim(m_cur)) % (lim(m_cur) + 1);
          if (rs[2]) m_cur = (m_cur + 1) % 4;
        end
      end
      1: if (done) begin
        m_mode = 2; m_t = 0; m_alarm = 1'b1;
      end
      default: begin
        if (any) begin
          m_mode = 0; m_alarm = 1'b0;
        end else begin
          m_t++;
          if (m_t >= H * T) begin
            m_mode = 0; m_alarm = 1'b0;
          end else begin
            m_alarm = ((m_t / H) % 2 == 0);
          end
        end
      end
    endcase
    for (int i = 0; i < 5; i++) m_prev[i] = btns[i];
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    if (start === 1'b1) start_seen++;
    chk("min",    32'(min),    m_dig[3] * 10 + m_dig[2]);
    chk("sec",    32'(sec),    m_dig[1] * 10 + m_dig[0]);
    chk("cursor", 32'(cursor), m_cur);
    chk("start",  32'(start),  int'(m_start));
    chk("busy",   32'(busy),   (m_mode == 1) ? 1 : 0);
    chk("alarm",  32'(alarm),  int'(m_alarm));
  endtask

  task automatic press(input int i);
    btns[i] = 1'b1;
    cyc();
    btns[i] = 1'b0;
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_min"},    32'(min),    0);
    chk({tag, "_sec"},    32'(sec),    0);
    chk({tag, "_cursor"}, 32'(cursor), 0);
    chk({tag, "_start"},  32'(start),  0);
    chk({tag, "_busy"},   32'(busy),   0);
    chk({tag, "_alarm"},  32'(alarm),  0);
  endtask

  initial begin
    int s0;
    btns = '0;
    done = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) cyc();

    // edit and start: 00:03 -> cursor 1 -> 00:23 -> start
    repeat (3) press(0);
    press(2);
    repeat (2) press(0);
    s0 = start_seen;
    btns[4] = 1'b1;
    cyc();
    chk("s1_start_pulse", 32'(start), 1);
    chk("s1_sec",  32'(sec), 23);
    chk("s1_min",  32'(min), 0);
    chk("s1_busy", 32'(busy), 1);
    btns[4] = 1'b0;
    repeat (3) cyc();
    chk("s1_single_start", 32'(start_seen - s0), 1);

    // run lockout
    press(0);
    press(3);
    chk("lock_sec",  32'(sec), 23);
    chk("lock_busy", 32'(busy), 1);

    // alarm full pattern
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("alarm_t0", 32'(alarm), 1);
    for (int i = 1; i <= 24; i++) begin
      cyc();
      if (i % 4 == 0) chk("alarm_pattern", 32'(alarm), (i < 24 && (i / 4) % 2 == 0) ? 1 : 0);
    end
    chk("alarm_end_busy", 32'(busy), 0);
    chk("alarm_end_sec",  32'(sec), 23);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("done_in_edit", 32'(alarm), 0);

    // wrap on seconds tens
    press(3);
    press(2);
    press(1);
    chk("wrap_down", 32'(sec), 50);
    press(0);
    chk("wrap_up_sec", 32'(sec), 0);
    chk("wrap_up_min", 32'(min), 0);

    // auto-repeat
    press(3);
    btns[0] = 1'b1;
    repeat (30) cyc();
    chk("rep_30", 32'(sec), 3);
    cyc();
    chk("rep_31", 32'(sec), 4);
    btns[0] = 1'b0;
    cyc();

    // zero start ignored
    press(3);
    s0 = start_seen;
    press(4);
    chk("zero_start", 32'(start_seen - s0), 0);
    chk("zero_busy",  32'(busy), 0);

    // silence mid-alarm with next: no cursor move
    press(0);
    press(4);
    done = 1'b1;
    cyc();
    done = 1'b0;
    repeat (5) cyc();
    btns[2] = 1'b1;
    cyc();
    chk("silence_alarm",  32'(alarm), 0);
    chk("silence_busy",   32'(busy), 0);
    chk("silence_cursor", 32'(cursor), 0);
    btns[2] = 1'b0;
    cyc();

    // reset mid-run with btn_up held
    press(4);
    chk("rr_busy", 32'(busy), 1);
    btns[0] = 1'b1;
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rr");
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (40) cyc();
    chk("rr_held_no_step", 32'(sec), 0);
    btns[0] = 1'b0;
    cyc();
    press(0);
    chk("rr_repress", 32'(sec), 1);

    // random phase
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 5; i++) begin
        if (btns[i]) begin
          if ($urandom_range(0, (i < 2) ? 39 : 2) == 0) btns[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 11) == 0) btns[i] = 1'b1;
        end
      end
      done = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
